// File: rtl/output_error_unit_pkg.sv
// Shared widths, fixed-point constants and PLAN sigmoid breakpoints for the
// output-layer error stage and its sigmoid sub-block.
package output_error_unit_pkg;

  localparam int BITWIDTH = 18;
  localparam int QM       = 11;
  localparam int ACC_W    = 32;
  localparam int Q_ONE    = 1 << QM;
  localparam int SQ_W     = 2 * BITWIDTH;

  typedef logic signed [BITWIDTH-1:0] word_t;
  typedef logic        [BITWIDTH-2:0] mag_t;

  localparam word_t WORD_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam word_t WORD_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam mag_t  MAG_MAX  = '1;
  localparam mag_t  MAG_ONE  = mag_t'(Q_ONE);

  // Breakpoints 5.0, 2.375, 1.0 and segment offsets 0.84375, 0.625, 0.5 in QM.
  localparam mag_t PLAN_BP_SAT  = mag_t'(10240);
  localparam mag_t PLAN_BP_MID  = mag_t'(4864);
  localparam mag_t PLAN_BP_LOW  = mag_t'(2048);
  localparam mag_t PLAN_OFF_MID = mag_t'(1728);
  localparam mag_t PLAN_OFF_LOW = mag_t'(1280);
  localparam mag_t PLAN_OFF_CTR = mag_t'(1024);

  typedef enum logic [1:0] {
    SEG_SAT,
    SEG_MID,
    SEG_LOW,
    SEG_CTR
  } plan_seg_t;

  function automatic plan_seg_t plan_segment(input mag_t a);
    plan_seg_t seg;
    if (a >= PLAN_BP_SAT)      seg = SEG_SAT;
    else if (a >= PLAN_BP_MID) seg = SEG_MID;
    else if (a >= PLAN_BP_LOW) seg = SEG_LOW;
    else                       seg = SEG_CTR;
    return seg;
  endfunction

endpackage

// File: rtl/output_error_unit_plan_sigmoid.sv
// Two-stage shift-only PLAN sigmoid: S1 takes |z| and picks the segment,
// S2 evaluates the segment and mirrors it for negative inputs.
module plan_sigmoid
  import output_error_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [BITWIDTH-1:0] in_z,
  input  logic [BITWIDTH-1:0] in_target,
  input  logic                in_last,
  output logic                out_valid,
  output logic [BITWIDTH-1:0] out_sig,
  output logic [BITWIDTH-1:0] out_target,
  output logic                out_last
);

  logic                s1_valid;
  logic                s1_neg;
  logic                s1_last;
  mag_t                s1_mag;
  plan_seg_t           s1_seg;
  logic [BITWIDTH-1:0] s1_target;

  mag_t z_mag;
  mag_t seg_y;
  mag_t plan_y;

  // The most negative input has no positive twin, so clamp its magnitude.
  always_comb begin
    z_mag = mag_t'(in_z);
    if (in_z == WORD_MIN)          z_mag = MAG_MAX;
    else if (in_z[BITWIDTH-1])     z_mag = mag_t'(-in_z);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_neg    <= 1'b0;
      s1_last   <= 1'b0;
      s1_mag    <= '0;
      s1_seg    <= SEG_CTR;
      s1_target <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_neg    <= in_z[BITWIDTH-1];
      s1_last   <= in_last;
      s1_mag    <= z_mag;
      s1_seg    <= plan_segment(z_mag);
      s1_target <= in_target;
    end
  end

  always_comb begin
    seg_y = MAG_ONE;
    case (s1_seg)
      SEG_SAT: seg_y = MAG_ONE;
      SEG_MID: seg_y = (s1_mag >> 5) + PLAN_OFF_MID;
      SEG_LOW: seg_y = (s1_mag >> 3) + PLAN_OFF_LOW;
      default: seg_y = (s1_mag >> 2) + PLAN_OFF_CTR;
    endcase
    plan_y = s1_neg ? (MAG_ONE - seg_y) : seg_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sig    <= '0;
      out_target <= '0;
      out_last   <= 1'b0;
    end else if (en) begin
      out_valid  <= s1_valid;
      out_sig    <= {1'b0, plan_y};
      out_target <= s1_target;
      out_last   <= s1_last;
    end
  end

endmodule

// File: rtl/output_error_unit.sv
// Output-layer error stage: sigmoid(z), saturated error target - sigmoid(z),
// and a per-sequence saturating sum of squared errors.
module output_error_unit
  import output_error_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_z,
  input  logic [BITWIDTH-1:0] in_target,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_sig,
  output logic [BITWIDTH-1:0] out_err,
  output logic                out_last,
  output logic                cost_valid,
  output logic [ACC_W-1:0]    cost
);

  logic                advance;
  logic                s2_valid;
  logic [BITWIDTH-1:0] s2_sig;
  logic [BITWIDTH-1:0] s2_target;
  logic                s2_last;

  logic signed [BITWIDTH:0] err_wide;
  word_t                    err_sat;
  logic signed [SQ_W-1:0]   sq_full;
  logic signed [SQ_W-1:0]   sq_shift;
  logic        [SQ_W:0]     acc_sum;
  logic        [ACC_W-1:0]  acc_next;
  logic        [ACC_W-1:0]  acc;

  // The whole pipe moves in lockstep; only a held, unaccepted output stalls it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  plan_sigmoid u_plan_sigmoid (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (advance),
    .in_valid   (in_valid),
    .in_z       (in_z),
    .in_target  (in_target),
    .in_last    (in_last),
    .out_valid  (s2_valid),
    .out_sig    (s2_sig),
    .out_target (s2_target),
    .out_last   (s2_last)
  );

  assign err_wide = $signed({s2_target[BITWIDTH-1], s2_target}) - $signed({1'b0, s2_sig});

  always_comb begin
    err_sat = err_wide[BITWIDTH-1:0];
    if (err_wide[BITWIDTH] != err_wide[BITWIDTH-1])
      err_sat = err_wide[BITWIDTH] ? WORD_MIN : WORD_MAX;
  end

  // The square is never negative, so the widened sum only needs an upper clamp.
  assign sq_full  = err_sat * err_sat;
  assign sq_shift = sq_full >>> QM;
  assign acc_sum  = {{(SQ_W+1-ACC_W){1'b0}}, acc} + {1'b0, sq_shift};
  assign acc_next = (|acc_sum[SQ_W:ACC_W]) ? '1 : acc_sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sig    <= '0;
      out_err    <= '0;
      out_last   <= 1'b0;
      cost_valid <= 1'b0;
      cost       <= '0;
      acc        <= '0;
    end else begin
      cost_valid <= 1'b0;
      if (advance) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_sig  <= s2_sig;
          out_err  <= err_sat;
          out_last <= s2_last;
          if (s2_last) begin
            cost       <= acc_next;
            acc        <= '0;
            cost_valid <= 1'b1;
          end else begin
            acc <= acc_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_output_error_unit.sv
// Self-checking bench for output_error_unit: directed corner cases plus a
// randomized handshake stream compared against a queue-based reference model.
module tb_output_error_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_z = '0;
  logic [17:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_sig;
  logic [17:0] out_err;
  logic        out_last;
  logic        cost_valid;
  logic [31:0] cost;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sig;
    int err;
    bit last;
  } exp_t;

  exp_t   exp_q[$];
  longint cost_q[$];
  longint model_acc = 0;
  exp_t   exp_item;
  bit     prev_ov = 1'b0;
  bit     prev_acc = 1'b0;
  bit     fresh;
  bit     exp_cv;
  bit     last_xfer = 1'b0;

  always #5 clk = ~clk;

  output_error_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z       (in_z),
    .in_target  (in_target),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sig    (out_sig),
    .out_err    (out_err),
    .out_last   (out_last),
    .cost_valid (cost_valid),
    .cost       (cost)
  );

  function automatic int to_int18(input logic [17:0] v);
    return int'($signed(v));
  endfunction

  // Reference sigmoid straight from the segment table, in plain integers.
  function automatic int sig_ref(input int z);
    int a;
    int y;
    a = (z < 0) ? -z : z;
    if (a > 131071) a = 131071;
    if (a >= 10240)     y = 2048;
    else if (a >= 4864) y = a / 32 + 1728;
    else if (a >= 2048) y = a / 8 + 1280;
    else                y = a / 4 + 1024;
    if (z < 0) y = 2048 - y;
    return y;
  endfunction

  function automatic int err_ref(input int t, input int y);
    int e;
    e = t - y;
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
    return e;
  endfunction

  function automatic longint sq_ref(input int e);
    return (longint'(e) * longint'(e)) / 2048;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: sampled on the falling edge, predicts the handshakes of the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      fresh  = !prev_ov || prev_acc;
      exp_cv = out_valid && fresh && (exp_q.size() > 0) && exp_q[0].last;
      checkOutput("cost_valid", cost_valid, exp_cv);
      if (cost_valid) begin
        if (cost_q.size() == 0) checkOutput("cost_pending", cost_q.size(), 1);
        else checkOutput("cost", longint'(cost), cost_q.pop_front());
      end
      checkOutput("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("out_pending", exp_q.size(), 1);
        end else begin
          checkOutput("out_sig", to_int18(out_sig), exp_q[0].sig);
          checkOutput("out_err", to_int18(out_err), exp_q[0].err);
          checkOutput("out_last", out_last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_item.sig  = sig_ref(to_int18(in_z));
        exp_item.err  = err_ref(to_int18(in_target), exp_item.sig);
        exp_item.last = in_last;
        exp_q.push_back(exp_item);
        model_acc += sq_ref(exp_item.err);
        if (model_acc > 64'hffff_ffff) model_acc = 64'hffff_ffff;
        if (in_last) begin
          cost_q.push_back(model_acc);
          model_acc = 0;
        end
      end
      prev_ov  = out_valid;
      prev_acc = out_valid && out_ready;
    end else begin
      exp_q.delete();
      cost_q.delete();
      model_acc = 0;
      prev_ov   = 1'b0;
      prev_acc  = 1'b0;
    end
    last_xfer = rst_n && in_valid && in_ready;
  end

  // Presents one element (caller is just after a rising edge) and returns after it is taken.
  task automatic sendOne(input logic [17:0] z, input logic [17:0] t, input logic l);
    bit taken;
    in_valid  = 1'b1;
    in_z      = z;
    in_target = t;
    in_last   = l;
    taken     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) checkOutput("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitCost(input string name, input longint exp_cost);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cost_valid) break;
    end
    checkOutput({name, "_seen"}, cost_valid, 1);
    if (cost_valid) checkOutput(name, longint'(cost), exp_cost);
  endtask

  task automatic applyStimulus(input int n_cycles, input int valid_pct, input int ready_pct);
    for (int c = 0; c < n_cycles; c++) begin
      @(posedge clk);
      #1;
      if (!in_valid || last_xfer) begin
        in_valid = ($urandom_range(0, 99) < valid_pct);
        if ($urandom_range(0, 1) == 1) in_z = 18'($urandom);
        else                           in_z = 18'($urandom_range(0, 24000) - 12000);
        case ($urandom_range(0, 3))
          0:       in_target = 18'h00000;
          1:       in_target = 18'h00800;
          2:       in_target = 18'($urandom);
          default: in_target = 18'($urandom_range(0, 4096));
        endcase
        in_last = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Pin the reference model with hand-worked values.
    checkOutput("ref_sig_zero", sig_ref(0), 1024);
    checkOutput("ref_sig_mid_pos", sig_ref(8495), 1993);
    checkOutput("ref_sig_mid_neg", sig_ref(-8495), 55);
    checkOutput("ref_sig_low", sig_ref(3000), 1655);
    checkOutput("ref_sig_sat_pos", sig_ref(10240), 2048);
    checkOutput("ref_sig_sat_neg", sig_ref(-10240), 0);
    checkOutput("ref_sig_min", sig_ref(-131072), 0);
    checkOutput("ref_err_clamp", err_ref(-131072, 2048), -131072);
    checkOutput("ref_sq_half", sq_ref(1024), 512);

    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_cost_valid", cost_valid, 0);
    checkOutput("rst_out_sig", out_sig, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_cost", cost, 0);
    #10;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    // Latency: transfer edge, then output visible after the third rising edge.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_z      = 18'h00000;
    in_target = 18'h00800;
    in_last   = 1'b1;
    @(posedge clk);
    #1;
    idleInputs();
    @(negedge clk);
    checkOutput("lat_c1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_c2_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_c3_valid", out_valid, 1);
    checkOutput("lat_sig", out_sig, 18'h00400);
    checkOutput("lat_err", out_err, 18'h00400);
    checkOutput("lat_cost", cost, 32'h200);

    // Four-element sequence, then a fresh single-element one.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) sendOne(18'h00000, 18'h00800, i == 3);
    idleInputs();
    waitCost("cost_seq4", 32'h800);
    @(posedge clk);
    #1;
    sendOne(18'h00000, 18'h00800, 1'b1);
    idleInputs();
    waitCost("cost_seq1", 32'h200);

    // Segment and magnitude corners, each its own sequence.
    @(posedge clk);
    #1;
    sendOne(18'h0212f, 18'h00000, 1'b1);
    sendOne(18'h3ded1, 18'h00000, 1'b1);
    sendOne(18'h02800, 18'h00800, 1'b1);
    sendOne(18'h3d800, 18'h00800, 1'b1);
    sendOne(18'h1f000, 18'h00000, 1'b1);
    sendOne(18'h20000, 18'h00800, 1'b1);
    sendOne(18'h00800, 18'h00800, 1'b1);
    sendOne(18'h01300, 18'h00000, 1'b1);
    idleInputs();
    repeat (6) @(posedge clk);
    #1;

    // Error clamps at the negative limit; cost clamps at 2**32-1.
    for (int i = 0; i < 600; i++) sendOne(18'h02800, 18'h20000, i == 599);
    idleInputs();
    waitCost("cost_sat", 32'hffff_ffff);

    applyStimulus(1500, 80, 60);
    idleInputs();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset while a sequence is in flight.
    for (int i = 0; i < 4; i++) sendOne(18'($urandom_range(0, 8000)), 18'h00800, 1'b0);
    #3;
    checkOutput("pre_rst_valid", out_valid, 1);
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_cost_valid", cost_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_rst_cost_valid", cost_valid, 0);
    @(posedge clk);
    #1;
    sendOne(18'h00000, 18'h00800, 1'b1);
    idleInputs();
    waitCost("cost_after_rst", 32'h200);

    applyStimulus(800, 90, 50);
    idleInputs();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && cost_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_out", exp_q.size(), 0);
    checkOutput("drain_cost", cost_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
